// File: rtl/fp_result_buffer_pkg.sv
// Shared types and FP32 field constants for fp_result_buffer and FP units that reuse fp_classify.
package fp_result_buffer_pkg;

    localparam int          FP32_SIGN_BIT = 31;
    localparam int          FP32_EXP_MSB  = 30;
    localparam int          FP32_EXP_LSB  = 23;
    localparam int          FP32_MANT_MSB = 22;
    localparam int          FP32_MANT_LSB = 0;
    localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;
    localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] FP32_POS_INF  = 32'h7F80_0000;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

    typedef struct packed {
        logic isNan;
        logic isInf;
        logic isDenorm;
        logic isZero;
    } fp_class_t;

    function automatic occ_t occ_of(input int count, input int depth);
        if (count == 0)          return OCC_EMPTY;
        else if (count >= depth) return OCC_FULL;
        else                     return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/fp_result_buffer_if.sv
// Producer/consumer stream and status signals of fp_result_buffer.
// Status flag ports exist only when FP_RESULT_STATUS_EN is defined.
interface fp_result_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  validIn;
    logic [DATA_WIDTH-1:0] dataIn;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  validOut;
    logic                  readyIn;
    logic [CW-1:0]         countOut;
    logic [CW-1:0]         creditOut;
    logic                  overflowOut;
    logic                  clearIn;
`ifdef FP_RESULT_STATUS_EN
    logic                  nanFlagOut;
    logic                  infFlagOut;
    logic                  denormFlagOut;
`endif

    modport master (
        output validIn, dataIn, readyIn, clearIn,
`ifdef FP_RESULT_STATUS_EN
        input  nanFlagOut, infFlagOut, denormFlagOut,
`endif
        input  dataOut, validOut, countOut, creditOut, overflowOut
    );

    modport slave (
        input  validIn, dataIn, readyIn, clearIn,
`ifdef FP_RESULT_STATUS_EN
        output nanFlagOut, infFlagOut, denormFlagOut,
`endif
        output dataOut, validOut, countOut, creditOut, overflowOut
    );

endinterface

// File: rtl/fp_classify.sv
// Combinational FP32 classifier: NaN / infinity / denormal / zero.
module fp_classify
    import fp_result_buffer_pkg::*;
(
    input  logic [31:0] word,
    output fp_class_t   cls
);
    logic [7:0]  exp_f;
    logic [22:0] mant_f;

    assign exp_f  = word[FP32_EXP_MSB:FP32_EXP_LSB];
    assign mant_f = word[FP32_MANT_MSB:FP32_MANT_LSB];

    assign cls.isNan    = (exp_f == FP32_EXP_MAX) && (mant_f != '0);
    assign cls.isInf    = (exp_f == FP32_EXP_MAX) && (mant_f == '0);
    assign cls.isDenorm = (exp_f == '0) && (mant_f != '0);
    assign cls.isZero   = (exp_f == '0) && (mant_f == '0);

endmodule

// File: rtl/fp_result_buffer.sv
// Receive-side FWFT buffer for pipelined FP results with credit export.
// Define FP_RESULT_STATUS_EN to add sticky NaN/Inf/denormal flags on accepted pushes.
module fp_result_buffer
    import fp_result_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PIPE_LAT   = 0
) (
    input  logic               clkIn,
    input  logic               rstIn,
    fp_result_buffer_if.slave  bus
);
    localparam int PW         = $clog2(DEPTH);
    localparam int CW         = PW + 1;
    localparam int CREDIT_MAX = DEPTH - PIPE_LAT;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_ptr_inc;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    occ_t                  occ;
    logic                  push;
    logic                  pop;
    logic                  drop;

    assign rd_ptr_inc = rd_ptr + PW'(1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pop        = bus.validOut & bus.readyIn;
        push       = bus.validIn & ((occ != OCC_FULL) | pop);
        drop       = bus.validIn & (occ == OCC_FULL) & ~pop;
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: storage is not reset; count/validOut decide which entries are meaningful.
    always_ff @(posedge clkIn) begin
        if (push) mem[wr_ptr] <= bus.dataIn;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            occ             <= OCC_EMPTY;
            bus.validOut    <= 1'b0;
            bus.dataOut     <= '0;
            bus.overflowOut <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            count        <= count_next;
            occ          <= occ_of(int'(count_next), DEPTH);
            bus.validOut <= (count_next != '0);

            // Head register tracks the oldest entry; a lone entry popped while a
            // new word arrives hands the head straight to the incoming word.
            if (pop) begin
                if (count > CW'(1)) bus.dataOut <= mem[rd_ptr_inc];
                else if (push)      bus.dataOut <= bus.dataIn;
            end else if (push && occ == OCC_EMPTY) begin
                bus.dataOut <= bus.dataIn;
            end

            if (drop)             bus.overflowOut <= 1'b1;
            else if (bus.clearIn) bus.overflowOut <= 1'b0;
        end
    end

    assign bus.countOut  = count;
    assign bus.creditOut = (count >= CW'(CREDIT_MAX)) ? '0 : CW'(CREDIT_MAX) - count;

`ifdef FP_RESULT_STATUS_EN
    fp_class_t cls;

    fp_classify u_classify (
        .word (bus.dataIn[31:0]),
        .cls  (cls)
    );

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            bus.nanFlagOut    <= 1'b0;
            bus.infFlagOut    <= 1'b0;
            bus.denormFlagOut <= 1'b0;
        end else begin
            if (push && cls.isNan)    bus.nanFlagOut    <= 1'b1;
            else if (bus.clearIn)     bus.nanFlagOut    <= 1'b0;
            if (push && cls.isInf)    bus.infFlagOut    <= 1'b1;
            else if (bus.clearIn)     bus.infFlagOut    <= 1'b0;
            if (push && cls.isDenorm) bus.denormFlagOut <= 1'b1;
            else if (bus.clearIn)     bus.denormFlagOut <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fp_result_buffer.sv
// Directed and scoreboard bench for fp_result_buffer (DEPTH=8, PIPE_LAT=0).
module tb_fp_result_buffer;
    import fp_result_buffer_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic clkIn = 1'b0;
    logic rstIn = 1'b1;
    always #5 clkIn = ~clkIn;

    fp_result_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fp_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PIPE_LAT(0)) dut (
        .clkIn (clkIn),
        .rstIn (rstIn),
        .bus   (bus)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        c;
        logic        ev;
        logic [31:0] ed;
        logic        chk_d;
        logic [3:0]  ecnt;
        logic [3:0]  ecred;
        logic        eovf;
    } vec_t;

    vec_t        vecs [13];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] q [$];
    logic        ovf_m    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic c);
        bus.validIn = v;
        bus.dataIn  = d;
        bus.readyIn = r;
        bus.clearIn = c;
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    // One cycle against the queue model: checks the head on pops, then state after the edge.
    task automatic model_step(input logic v, input logic [31:0] d, input logic r);
        logic pop_m, push_m, full_m;
        pop_m  = (q.size() > 0) && r;
        full_m = (q.size() == DEPTH);
        push_m = v && (!full_m || pop_m);
        if (pop_m) check("pop_data", bus.dataOut, q[0]);
        if (v && full_m && !pop_m) ovf_m = 1'b1;
        drive(v, d, r, 1'b0);
        tick();
        if (pop_m)  void'(q.pop_front());
        if (push_m) q.push_back(d);
        check("count", 32'(bus.countOut), 32'(q.size()));
        check("valid", 32'(bus.validOut), 32'(q.size() > 0));
        check("overflow", 32'(bus.overflowOut), 32'(ovf_m));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h3F80_0000, 1'b1, 1'b0, 1'b1, 32'h3F80_0000, 1'b1, 4'd1, 4'd7, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 4'd0, 4'd8, 1'b0};
        for (int i = 2; i <= 9; i++)
            vecs[i] = '{1'b1, 32'h100 + 32'(i - 1), 1'b0, 1'b0, 1'b1, 32'h101, 1'b1,
                        4'(i - 1), 4'(9 - i), 1'b0};
        vecs[10] = '{1'b1, 32'hDEAD,      1'b0, 1'b0, 1'b1, 32'h101,       1'b1, 4'd8, 4'd0, 1'b1};
        vecs[11] = '{1'b1, 32'hBEEF,      1'b0, 1'b1, 1'b1, 32'h101,       1'b1, 4'd8, 4'd0, 1'b1};
        vecs[12] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h101,       1'b1, 4'd8, 4'd0, 1'b0};

        drive(1'b0, '0, 1'b0, 1'b0);
        rstIn = 1'b1;
        tick();
        tick();
        rstIn = 1'b0;
        check("rst_valid",    32'(bus.validOut),    32'd0);
        check("rst_data",     bus.dataOut,          32'd0);
        check("rst_count",    32'(bus.countOut),    32'd0);
        check("rst_credit",   32'(bus.creditOut),   32'd8);
        check("rst_overflow", 32'(bus.overflowOut), 32'd0);
`ifdef FP_RESULT_STATUS_EN
        check("rst_nan", 32'(bus.nanFlagOut), 32'd0);
`endif

        // Single word through, fill to FULL, overflow drop, set-wins clear, then clear.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(bus.validOut), 32'(vecs[i].ev));
            if (vecs[i].chk_d)
                check($sformatf("vec%0d_data", i), bus.dataOut, vecs[i].ed);
            check($sformatf("vec%0d_count", i),    32'(bus.countOut),    32'(vecs[i].ecnt));
            check($sformatf("vec%0d_credit", i),   32'(bus.creditOut),   32'(vecs[i].ecred));
            check($sformatf("vec%0d_overflow", i), 32'(bus.overflowOut), 32'(vecs[i].eovf));
        end

        // Drain the eight stored words; the dropped ones must not appear.
        for (int i = 1; i <= 8; i++) q.push_back(32'h100 + 32'(i));
        for (int i = 0; i < 8; i++) model_step(1'b0, '0, 1'b1);

        // FULL with simultaneous push and pop for 20 cycles: no drops, order kept.
        for (int i = 0; i < 8; i++)  model_step(1'b1, 32'h200 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) model_step(1'b1, 32'h300 + 32'(i), 1'b1);
        check("full_stream_credit", 32'(bus.creditOut), 32'd0);

        for (int i = 0; i < 3000; i++)
            model_step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));

        // Mid-stream reset discards contents.
        for (int i = 0; i < 5; i++) model_step(1'b1, 32'h400 + 32'(i), 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        rstIn = 1'b1;
        tick();
        rstIn = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        check("midrst_valid",    32'(bus.validOut),    32'd0);
        check("midrst_count",    32'(bus.countOut),    32'd0);
        check("midrst_credit",   32'(bus.creditOut),   32'd8);
        check("midrst_overflow", 32'(bus.overflowOut), 32'd0);
        model_step(1'b1, 32'h3F80_0000, 1'b1);
        check("post_rst_data", bus.dataOut, 32'h3F80_0000);
        model_step(1'b0, '0, 1'b1);

`ifdef FP_RESULT_STATUS_EN
        model_step(1'b1, FP32_QNAN,    1'b1);
        model_step(1'b1, 32'hFF80_0000, 1'b1);
        model_step(1'b1, 32'h0000_0001, 1'b1);
        check("nan_flag",    32'(bus.nanFlagOut),    32'd1);
        check("inf_flag",    32'(bus.infFlagOut),    32'd1);
        check("denorm_flag", 32'(bus.denormFlagOut), 32'd1);
        drive(1'b0, '0, 1'b1, 1'b1);
        tick();
        check("nan_clear",    32'(bus.nanFlagOut),    32'd0);
        check("inf_clear",    32'(bus.infFlagOut),    32'd0);
        check("denorm_clear", 32'(bus.denormFlagOut), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
